// File: rtl/alu_seq_pkg.sv
// Shared constants for the accumulator sequencer: memory depth,
// opcode encodings and the controller state encoding.
package alu_seq_pkg;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int IW    = 7;

  // Opcodes; A = instruction data nibble, B = acc[3:0]
  localparam logic [2:0] OP_ADD4 = 3'b000;  // {cout, A+B} zero-extended
  localparam logic [2:0] OP_ADD8 = 3'b001;  // acc + A, wraps
  localparam logic [2:0] OP_SEXT = 3'b010;  // sign-extend B
  localparam logic [2:0] OP_OR   = 3'b011;  // reduction OR of {A,B}
  localparam logic [2:0] OP_AND  = 3'b100;  // reduction AND of {A,B}
  localparam logic [2:0] OP_SHL  = 3'b101;  // A << B, truncated
  localparam logic [2:0] OP_MUL  = 3'b110;  // A * B
  localparam logic [2:0] OP_NOP  = 3'b111;  // acc unchanged

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Program/control/status bundle of the sequencer. The master side
// (host or bench) drives programming and run control; the slave side
// (alu_seq_ctrl) returns status and the accumulator.
interface alu_seq_ctrl_if;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [6:0] prog_data;
  logic [2:0] last_addr;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] acc;
  logic [2:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, last_addr, start, abort,
    input  busy, done, acc, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, last_addr, start, abort,
    output busy, done, acc, pc
  );
endinterface

// File: rtl/alu_core.sv
// Combinational operation datapath: computes the next accumulator value
// from the opcode, the instruction data nibble and the current acc.
module alu_core
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [7:0] acc,
  output logic [7:0] result
);

  logic [3:0] b_s;
  logic [4:0] sum5_s;
  logic [7:0] shl_s;
  logic [7:0] mul_s;

  // Operand preparation and result selection for every opcode
  always_comb begin
    b_s    = acc[3:0];
    sum5_s = {1'b0, a} + {1'b0, b_s};
    shl_s  = {4'b0000, a} << b_s;
    mul_s  = {4'b0000, a} * {4'b0000, b_s};
    result = acc;
    case (op)
      OP_ADD4: result = {3'b000, sum5_s};
      OP_ADD8: result = acc + {4'b0000, a};
      OP_SEXT: result = {{4{b_s[3]}}, b_s};
      OP_OR:   result = {7'b0000000, |{a, b_s}};
      OP_AND:  result = {7'b0000000, &{a, b_s}};
      OP_SHL:  result = shl_s;
      OP_MUL:  result = mul_s;
      OP_NOP:  result = acc;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Accumulator sequencer: an 8-word instruction memory programmed while
// idle, and a FETCH/EXEC controller that runs addresses 0..last_addr,
// applying each instruction to the persistent accumulator.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic           Clock,
  input  logic           Reset_b,
  alu_seq_ctrl_if.slave  bus
);

  logic [IW-1:0] mem_r [DEPTH];
  state_t        state_r;
  logic [IW-1:0] ir_r;
  logic [7:0]    acc_r;
  logic [AW-1:0] pc_r;
  logic [AW-1:0] last_r;
  logic          busy_r;
  logic          done_r;
  logic [7:0]    alu_result_s;

  alu_core u_alu_core (
    .op     (ir_r[6:4]),
    .a      (ir_r[3:0]),
    .acc    (acc_r),
    .result (alu_result_s)
  );

  // Instruction memory: cleared by reset, writable only while idle so a
  // running program can never be modified underneath the controller
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 7'b0000000;
      end
    end else if ((state_r == ST_IDLE) && bus.prog_we) begin
      mem_r[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Run controller with registered busy/done/pc/acc; done is raised on
  // the DONE->IDLE edge so it is only seen after a complete run
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_r <= ST_IDLE;
      ir_r    <= 7'b0000000;
      acc_r   <= 8'h00;
      pc_r    <= 3'd0;
      last_r  <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          pc_r <= 3'd0;
          if (bus.start) begin
            last_r  <= bus.last_addr;
            busy_r  <= 1'b1;
            state_r <= ST_FETCH;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (bus.abort) begin
            pc_r    <= 3'd0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            ir_r    <= mem_r[pc_r];
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (bus.abort) begin
            pc_r    <= 3'd0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            acc_r <= alu_result_s;
            if (pc_r == last_r) begin
              busy_r  <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              pc_r    <= pc_r + 3'd1;
              state_r <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          pc_r    <= 3'd0;
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          pc_r    <= 3'd0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.acc  = acc_r;
  assign bus.pc   = pc_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: hand-computed accumulator traces,
// done/busy timing, abort, mid-run reset and idle-only programming.
module tb_alu_seq_ctrl;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;
  logic [7:0] acc_hist [0:63];
  int   done_cyc;
  int   busy_cyc;
  int   done_pulses;
  int   first_done;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .Clock   (clk),
    .Reset_b (rst_b),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [2:0] addr, input logic [2:0] op, input logic [3:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = {op, data};
    step();
    bus.prog_we   = 1'b0;
  endtask

  // Start a run, then observe `budget` cycles after the start edge.
  // abort_at = sample index after which abort is held for one edge.
  task automatic run_prog(input logic [2:0] la, input int abort_at, input int budget,
                          output int d_cyc, output int b_cyc, output int pulses);
    bus.last_addr = la;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.last_addr = ~la;
    b_cyc  = (bus.busy === 1'b1) ? 1 : 0;
    d_cyc  = -1;
    pulses = 0;
    acc_hist[0] = bus.acc;
    for (int c = 1; c <= budget; c++) begin
      if (c - 1 == abort_at) bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      acc_hist[c] = bus.acc;
      if (bus.busy === 1'b1) b_cyc++;
      if (bus.done === 1'b1) begin
        pulses++;
        if (d_cyc < 0) d_cyc = c;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_b  = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = 3'd0; bus.prog_data = 7'd0;
    bus.last_addr = 3'd0; bus.start = 1'b0; bus.abort = 1'b0;
    #3;
    check_val("rst_acc",  {24'd0, bus.acc}, 32'h00);
    check_val("rst_pc",   {29'd0, bus.pc}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    step();
    rst_b = 1'b1;
    step();

    // Reference program: 05, 0F, FF; last_addr changed mid-run is ignored
    prog(3'd0, 3'b001, 4'h5);
    prog(3'd1, 3'b110, 4'h3);
    prog(3'd2, 3'b010, 4'h0);
    run_prog(3'd2, -1, 10, done_cyc, busy_cyc, done_pulses);
    check_val("a_fetch_acc", {24'd0, acc_hist[1]}, 32'h00);
    check_val("a_acc0", {24'd0, acc_hist[2]}, 32'h05);
    check_val("a_acc1", {24'd0, acc_hist[4]}, 32'h0F);
    check_val("a_acc2", {24'd0, acc_hist[6]}, 32'hFF);
    check_val("a_done_cyc", done_cyc, 32'd7);
    check_val("a_busy_cyc", busy_cyc, 32'd6);
    check_val("a_pulses", done_pulses, 32'd1);
    check_val("a_pc_idle", {29'd0, bus.pc}, 32'd0);

    // Single instruction, 8-bit wrap: FF + 2 = 01
    prog(3'd0, 3'b001, 4'h2);
    run_prog(3'd0, -1, 6, done_cyc, busy_cyc, done_pulses);
    check_val("b_wrap", {24'd0, bus.acc}, 32'h01);
    check_val("b_done_cyc", done_cyc, 32'd3);
    check_val("b_busy_cyc", busy_cyc, 32'd2);

    // 0F + F with carry -> 1E
    prog(3'd0, 3'b100, 4'h0);
    prog(3'd1, 3'b001, 4'hF);
    prog(3'd2, 3'b000, 4'hF);
    run_prog(3'd2, -1, 9, done_cyc, busy_cyc, done_pulses);
    check_val("c_setup", {24'd0, acc_hist[4]}, 32'h0F);
    check_val("c_add4", {24'd0, bus.acc}, 32'h1E);

    // 02, shift 3<<2 -> 0C
    prog(3'd1, 3'b001, 4'h2);
    prog(3'd2, 3'b101, 4'h3);
    run_prog(3'd2, -1, 9, done_cyc, busy_cyc, done_pulses);
    check_val("d_shl", {24'd0, bus.acc}, 32'h0C);

    // 0F AND-reduce F -> 01
    prog(3'd1, 3'b001, 4'hF);
    prog(3'd2, 3'b100, 4'hF);
    run_prog(3'd2, -1, 9, done_cyc, busy_cyc, done_pulses);
    check_val("e_and", {24'd0, bus.acc}, 32'h01);

    // 00 OR-reduce 0 -> 00, two instructions
    prog(3'd1, 3'b011, 4'h0);
    run_prog(3'd1, -1, 7, done_cyc, busy_cyc, done_pulses);
    check_val("f_or", {24'd0, bus.acc}, 32'h00);
    check_val("f_done_cyc", done_cyc, 32'd5);

    // Full 8-word program exercising every opcode
    prog(3'd0, 3'b001, 4'hF);  // 0F
    prog(3'd1, 3'b110, 4'hF);  // F*F = E1
    prog(3'd2, 3'b111, 4'h9);  // E1
    prog(3'd3, 3'b010, 4'h0);  // sext 1 = 01
    prog(3'd4, 3'b101, 4'hF);  // F<<1 = 1E
    prog(3'd5, 3'b101, 4'h1);  // 1<<14 truncated = 00
    prog(3'd6, 3'b001, 4'h9);  // 09
    prog(3'd7, 3'b000, 4'h8);  // 8+9 = 11 (carry)
    run_prog(3'd7, -1, 20, done_cyc, busy_cyc, done_pulses);
    check_val("g_mul",  {24'd0, acc_hist[4]}, 32'hE1);
    check_val("g_nop",  {24'd0, acc_hist[6]}, 32'hE1);
    check_val("g_sext", {24'd0, acc_hist[8]}, 32'h01);
    check_val("g_shl",  {24'd0, acc_hist[10]}, 32'h1E);
    check_val("g_shl_trunc", {24'd0, acc_hist[12]}, 32'h00);
    check_val("g_add8", {24'd0, acc_hist[14]}, 32'h09);
    check_val("g_add4_cout", {24'd0, acc_hist[16]}, 32'h11);
    check_val("g_done_cyc", done_cyc, 32'd17);

    // Abort in the second EXEC: acc keeps first result (11+1), no done
    prog(3'd0, 3'b001, 4'h1);
    prog(3'd1, 3'b001, 4'h2);
    prog(3'd2, 3'b001, 4'h4);
    run_prog(3'd2, 3, 10, done_cyc, busy_cyc, done_pulses);
    check_val("h_acc_first", {24'd0, acc_hist[2]}, 32'h12);
    check_val("h_acc_abort", {24'd0, acc_hist[4]}, 32'h12);
    check_val("h_busy_cyc", busy_cyc, 32'd4);
    check_val("h_no_done", done_pulses, 32'd0);
    check_val("h_pc", {29'd0, bus.pc}, 32'd0);

    // Abort held during DONE has no effect: 12+7 = 19, done still pulses
    run_prog(3'd2, 6, 10, done_cyc, busy_cyc, done_pulses);
    check_val("i_acc", {24'd0, bus.acc}, 32'h19);
    check_val("i_done_cyc", done_cyc, 32'd7);

    // Reset mid-run: immediate clear, memory zeroed
    bus.last_addr = 3'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    #2;
    rst_b = 1'b0;
    #1;
    check_val("j_acc",  {24'd0, bus.acc}, 32'h00);
    check_val("j_pc",   {29'd0, bus.pc}, 32'd0);
    check_val("j_busy", {31'd0, bus.busy}, 32'd0);
    check_val("j_done", {31'd0, bus.done}, 32'd0);
    step();
    rst_b = 1'b1;
    step();
    check_val("j_no_done", {31'd0, bus.done}, 32'd0);
    run_prog(3'd7, -1, 20, done_cyc, busy_cyc, done_pulses);
    check_val("j_zero_acc", {24'd0, bus.acc}, 32'h00);
    check_val("j_done_cyc", done_cyc, 32'd17);
    check_val("j_pulses", done_pulses, 32'd1);

    // Start held high, writes while busy/DONE ignored, restart after DONE
    prog(3'd0, 3'b001, 4'h3);
    bus.last_addr = 3'd0;
    done_pulses = 0;
    first_done  = -1;
    bus.start = 1'b1;
    step();
    for (int c = 1; c <= 10; c++) begin
      bus.prog_we   = ((c - 1 == 1) || (c - 1 == 2)) ? 1'b1 : 1'b0;
      bus.prog_addr = 3'd0;
      bus.prog_data = {3'b001, 4'h7};
      bus.start     = (c - 1 < 4) ? 1'b1 : 1'b0;
      step();
      if (bus.done === 1'b1) begin
        done_pulses++;
        if (first_done < 0) first_done = c;
      end
      if (c == 2) begin
        check_val("k_acc_run1", {24'd0, bus.acc}, 32'h03);
        check_val("k_busy_done", {31'd0, bus.busy}, 32'd0);
      end
      if (c == 4) check_val("k_restart", {31'd0, bus.busy}, 32'd1);
      if (c == 6) check_val("k_acc_run2", {24'd0, bus.acc}, 32'h06);
    end
    bus.prog_we = 1'b0;
    check_val("k_first_done", first_done, 32'd3);
    check_val("k_pulses", done_pulses, 32'd2);
    check_val("k_acc_final", {24'd0, bus.acc}, 32'h06);

    // Write and start in the same idle cycle: first FETCH sees new word
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'd0;
    bus.prog_data = {3'b001, 4'h5};
    run_prog(3'd0, -1, 6, done_cyc, busy_cyc, done_pulses);
    check_val("l_same_cycle", {24'd0, bus.acc}, 32'h0B);
    check_val("l_done_cyc", done_cyc, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
